// File: rtl/edf_port_scheduler_if.sv
// Bundle of requester, downstream-grant, configuration and status signals of the EDF scheduler.
// The master modport is the scheduler's view; slave is the surrounding fabric's view.
interface edf_port_scheduler_if #(
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned PORT_W    = 2,
    parameter int unsigned TS_W      = 16
);
    logic [NUM_PORTS-1:0] S_REQ_VALID;
    logic [NUM_PORTS-1:0] S_REQ_READY;
    logic                 M_VALID;
    logic [PORT_W-1:0]    M_PORT;
    logic                 M_READY;
    logic                 M_DONE;
    logic                 CFG_WE;
    logic [PORT_W-1:0]    CFG_PORT;
    logic [TS_W-1:0]      CFG_PERIOD;
    logic [TS_W-1:0]      TIMESTAMP;
    logic [NUM_PORTS-1:0] DEADLINE_MISS;

    modport master (
        input  S_REQ_VALID, M_READY, M_DONE, CFG_WE, CFG_PORT, CFG_PERIOD,
        output S_REQ_READY, M_VALID, M_PORT, TIMESTAMP, DEADLINE_MISS
    );

    modport slave (
        output S_REQ_VALID, M_READY, M_DONE, CFG_WE, CFG_PORT, CFG_PERIOD,
        input  S_REQ_READY, M_VALID, M_PORT, TIMESTAMP, DEADLINE_MISS
    );
endinterface

// File: rtl/edf_port_scheduler.sv
// Earliest-deadline-first arbiter sharing one downstream transaction port between NUM_PORTS
// requesters; deadlines are stamped at acceptance from per-port programmable periods.
module edf_port_scheduler #(
    parameter int unsigned NUM_PORTS      = 4,
    parameter int unsigned PORT_W         = 2,
    parameter int unsigned TS_W           = 16,
    parameter int unsigned DEFAULT_PERIOD = 64
) (
    input  logic                 ACLK,
    input  logic                 ARESET,
    edf_port_scheduler_if.master bus
);

    typedef enum logic [1:0] {StIdle, StGrant, StBusy} state_e;

    state_e state_q, state_d;
    logic [PORT_W-1:0] sel_q, sel_d;
    logic [TS_W-1:0]   ts_q;

    logic [NUM_PORTS-1:0] pending_q;
    logic [NUM_PORTS-1:0] missed_q;
    logic [TS_W-1:0]      deadline_q [NUM_PORTS];
    logic [TS_W-1:0]      period_q   [NUM_PORTS];

    logic [NUM_PORTS-1:0] req_ready;
    logic [NUM_PORTS-1:0] accept;
    logic [NUM_PORTS-1:0] miss;
    logic                 done_clr;
    logic                 m_valid;

    logic signed [TS_W-1:0] slack [NUM_PORTS];
    logic signed [TS_W-1:0] best_slack;
    logic [PORT_W-1:0]      cand;
    logic                   cand_found;
    logic                   in_service;

    // ------------------------------------------------------------------
    // Request handshake
    // ------------------------------------------------------------------
    always_comb begin
        req_ready = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            req_ready[i] = !pending_q[i] && !ARESET;
        end
        accept = bus.S_REQ_VALID & req_ready;
    end

    // ------------------------------------------------------------------
    // Candidate selection: minimum signed slack, lowest index on ties
    // ------------------------------------------------------------------
    assign in_service = (state_q != StIdle);

    always_comb begin
        cand       = '0;
        cand_found = 1'b0;
        best_slack = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            // Signed difference keeps ordering correct across timestamp wrap.
            slack[i] = $signed(deadline_q[i] - ts_q);
            if (pending_q[i] && !(in_service && sel_q == PORT_W'(i))) begin
                if (!cand_found || slack[i] < best_slack) begin
                    cand_found = 1'b1;
                    cand       = PORT_W'(i);
                    best_slack = slack[i];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Deadline miss detection
    // ------------------------------------------------------------------
    always_comb begin
        miss = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            miss[i] = pending_q[i] && !missed_q[i] && (ts_q == deadline_q[i])
                      && !(state_q == StBusy && sel_q == PORT_W'(i)) && !ARESET;
        end
    end

    // ------------------------------------------------------------------
    // Grant FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        m_valid  = 1'b0;
        done_clr = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cand_found) begin
                    sel_d   = cand;
                    state_d = StGrant;
                end
            end
            StGrant: begin
                m_valid = 1'b1;
                if (bus.M_READY) begin
                    state_d = StBusy;
                end
            end
            StBusy: begin
                if (bus.M_DONE) begin
                    done_clr = 1'b1;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q <= StIdle;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
        end
    end

    // ------------------------------------------------------------------
    // Timestamp and per-port state
    // ------------------------------------------------------------------
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            ts_q      <= '0;
            pending_q <= '0;
            missed_q  <= '0;
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                deadline_q[i] <= '0;
                period_q[i]   <= TS_W'(DEFAULT_PERIOD);
            end
        end else begin
            ts_q <= ts_q + TS_W'(1);
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                // Acceptance reads the period before any same-cycle write lands.
                if (accept[i]) begin
                    pending_q[i]  <= 1'b1;
                    deadline_q[i] <= ts_q + period_q[i];
                    missed_q[i]   <= 1'b0;
                end else begin
                    if (done_clr && sel_q == PORT_W'(i)) begin
                        pending_q[i] <= 1'b0;
                    end
                    if (miss[i]) begin
                        missed_q[i] <= 1'b1;
                    end
                end
                if (bus.CFG_WE && bus.CFG_PORT == PORT_W'(i)) begin
                    period_q[i] <= bus.CFG_PERIOD;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.S_REQ_READY   = req_ready;
    assign bus.M_VALID       = m_valid;
    assign bus.M_PORT        = sel_q;
    assign bus.TIMESTAMP     = ts_q;
    assign bus.DEADLINE_MISS = miss;

endmodule

// File: tb/tb_edf_port_scheduler.sv
// Self-checking bench for edf_port_scheduler: table of arbitration scenarios plus hand-written
// sequences for timing, deadline miss, reset, configuration and timestamp wrap.
module tb_edf_port_scheduler;

    localparam int unsigned N  = 4;
    localparam int unsigned PW = 2;
    localparam int unsigned TW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    edf_port_scheduler_if #(.NUM_PORTS(N), .PORT_W(PW), .TS_W(TW)) bus ();

    edf_port_scheduler #(
        .NUM_PORTS(N),
        .PORT_W(PW),
        .TS_W(TW),
        .DEFAULT_PERIOD(64)
    ) dut (
        .ACLK(clk),
        .ARESET(rst),
        .bus(bus)
    );

    typedef struct {
        logic [N-1:0]          req;
        logic [N-1:0][TW-1:0]  per;
        int                    n;
        logic [N-1:0][PW-1:0]  order;
    } vec_t;

    vec_t vecs [5];
    int   checks = 0;
    int   failures = 0;
    int   exp_q [$];
    int   miss_cnt [N] = '{default: 0};
    logic [TW-1:0] miss_ts [N];

    // Background deadline-miss recorder; sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                if (bus.DEADLINE_MISS[i]) begin
                    miss_cnt[i] = miss_cnt[i] + 1;
                    miss_ts[i]  = bus.TIMESTAMP;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
        $fatal(1);
    end

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pops the scoreboard when the DUT presents a grant that is being accepted.
    task automatic take_grant();
        int e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL grant_unexpected actual=%0d required=none", bus.M_PORT);
        end else begin
            e = exp_q.pop_front();
            check("grant_port", longint'(bus.M_PORT), longint'(e));
        end
    endtask

    task automatic service(input int n, input bit chk_gap);
        int w;
        for (int g = 0; g < n; g++) begin
            w = 0;
            while (!bus.M_VALID && w < 20) begin
                tick();
                w++;
            end
            check("grant_valid", longint'(bus.M_VALID), 1);
            if (!bus.M_VALID) return;
            if (chk_gap && g > 0) check("service_gap", w, 1);
            take_grant();
            tick();
            check("busy_m_valid", longint'(bus.M_VALID), 0);
            tick();
            bus.M_DONE = 1'b1;
            tick();
            bus.M_DONE = 1'b0;
        end
    endtask

    task automatic set_vec(input int v, input logic [N-1:0] req,
                           input int p0, input int p1, input int p2, input int p3,
                           input int n, input int o0, input int o1, input int o2, input int o3);
        vecs[v].req      = req;
        vecs[v].per[0]   = TW'(p0);
        vecs[v].per[1]   = TW'(p1);
        vecs[v].per[2]   = TW'(p2);
        vecs[v].per[3]   = TW'(p3);
        vecs[v].n        = n;
        vecs[v].order[0] = PW'(o0);
        vecs[v].order[1] = PW'(o1);
        vecs[v].order[2] = PW'(o2);
        vecs[v].order[3] = PW'(o3);
    endtask

    task automatic write_period(input int p, input int per);
        bus.CFG_WE     = 1'b1;
        bus.CFG_PORT   = PW'(p);
        bus.CFG_PERIOD = TW'(per);
        tick();
        bus.CFG_WE     = 1'b0;
    endtask

    initial begin
        logic [TW-1:0] acc_ts;
        int            base;
        int            w;

        bus.S_REQ_VALID = '0;
        bus.M_READY     = 1'b0;
        bus.M_DONE      = 1'b0;
        bus.CFG_WE      = 1'b0;
        bus.CFG_PORT    = '0;
        bus.CFG_PERIOD  = '0;

        //             req      p0   p1   p2   p3  n  order
        set_vec(0, 4'b1011, 100,  20,  64,  50, 3, 1, 3, 0, 0);
        set_vec(1, 4'b0101,  30,  64,  30,  64, 2, 0, 2, 0, 0);
        set_vec(2, 4'b1111,  10,  40,  30,  20, 4, 0, 3, 2, 1);
        set_vec(3, 4'b1110,  64,  64,  64,  64, 3, 1, 2, 3, 0);
        set_vec(4, 4'b0110,  64, 200,   7,  64, 2, 2, 1, 0, 0);

        // Reset state
        tick();
        tick();
        check("rst_m_valid", longint'(bus.M_VALID), 0);
        check("rst_m_port", longint'(bus.M_PORT), 0);
        check("rst_timestamp", longint'(bus.TIMESTAMP), 0);
        check("rst_miss", longint'(bus.DEADLINE_MISS), 0);
        check("rst_req_ready_in_reset", longint'(bus.S_REQ_READY), 0);
        rst = 1'b0;
        #1;
        check("rst_req_ready_after", longint'(bus.S_REQ_READY), 15);
        check("rst_timestamp_after", longint'(bus.TIMESTAMP), 0);

        // Single request on port 2 at TIMESTAMP=10
        repeat (10) tick();
        check("t1_timestamp", longint'(bus.TIMESTAMP), 10);
        bus.M_READY     = 1'b1;
        bus.S_REQ_VALID = 4'b0100;
        exp_q.push_back(2);
        tick();
        bus.S_REQ_VALID = '0;
        check("t1_pending_ready", longint'(bus.S_REQ_READY[2]), 0);
        check("t1_no_valid_yet", longint'(bus.M_VALID), 0);
        check("t1_deadline", longint'(dut.deadline_q[2]), 74);
        tick();
        check("t1_m_valid", longint'(bus.M_VALID), 1);
        take_grant();
        tick();
        check("t1_busy", longint'(bus.M_VALID), 0);
        tick();
        tick();
        bus.M_DONE = 1'b1;
        check("t1_ready_at_done", longint'(bus.S_REQ_READY[2]), 0);
        tick();
        bus.M_DONE = 1'b0;
        check("t1_ready_after_done", longint'(bus.S_REQ_READY[2]), 1);
        check("t1_idle", longint'(bus.M_VALID), 0);

        // Table-driven EDF order, tie-break and mixed scenarios
        for (int v = 0; v < 5; v++) begin
            for (int p = 0; p < N; p++) write_period(p, int'(vecs[v].per[p]));
            bus.M_READY     = 1'b0;
            bus.S_REQ_VALID = vecs[v].req;
            for (int k = 0; k < vecs[v].n; k++) exp_q.push_back(int'(vecs[v].order[k]));
            tick();
            bus.S_REQ_VALID = '0;
            tick();
            bus.M_READY = 1'b1;
            service(vecs[v].n, 1'b1);
            tick();
        end

        // Deadline miss: period 5 with downstream stalled
        write_period(1, 5);
        bus.M_READY     = 1'b0;
        bus.S_REQ_VALID = 4'b0010;
        acc_ts          = bus.TIMESTAMP;
        base            = miss_cnt[1];
        exp_q.push_back(1);
        tick();
        bus.S_REQ_VALID = '0;
        repeat (10) tick();
        check("t5_still_granted", longint'(bus.M_VALID), 1);
        check("t5_miss_once", miss_cnt[1] - base, 1);
        check("t5_miss_time", longint'(miss_ts[1]), longint'(TW'(acc_ts + 16'd5)));
        bus.M_READY = 1'b1;
        service(1, 1'b0);
        repeat (8) tick();
        check("t5_no_second_miss", miss_cnt[1] - base, 1);

        // Reset while in GRANT drops M_VALID on the next edge
        bus.M_READY     = 1'b0;
        bus.S_REQ_VALID = 4'b0001;
        tick();
        bus.S_REQ_VALID = '0;
        tick();
        check("t6_grant_before_rst", longint'(bus.M_VALID), 1);
        rst = 1'b1;
        tick();
        check("t6_grant_rst_m_valid", longint'(bus.M_VALID), 0);
        rst = 1'b0;
        tick();

        // Reset while in BUSY discards the request
        bus.M_READY     = 1'b1;
        bus.S_REQ_VALID = 4'b0010;
        exp_q.push_back(1);
        tick();
        bus.S_REQ_VALID = '0;
        tick();
        check("t6_busy_grant", longint'(bus.M_VALID), 1);
        take_grant();
        tick();
        check("t6_in_busy", longint'(bus.M_VALID), 0);
        rst = 1'b1;
        tick();
        check("t6_rst_m_valid", longint'(bus.M_VALID), 0);
        check("t6_rst_timestamp", longint'(bus.TIMESTAMP), 0);
        rst = 1'b0;
        #1;
        check("t6_ready_after_rst", longint'(bus.S_REQ_READY), 15);
        repeat (3) tick();
        check("t6_nothing_pending", longint'(bus.M_VALID), 0);

        // Period write in the same cycle as a port 3 acceptance
        bus.CFG_WE      = 1'b1;
        bus.CFG_PORT    = 2'd3;
        bus.CFG_PERIOD  = 16'd30;
        bus.S_REQ_VALID = 4'b1000;
        acc_ts          = bus.TIMESTAMP;
        exp_q.push_back(3);
        tick();
        bus.CFG_WE      = 1'b0;
        bus.S_REQ_VALID = '0;
        check("t6_old_period", longint'(dut.deadline_q[3]), longint'(TW'(acc_ts + 16'd64)));
        service(1, 1'b0);
        tick();
        bus.S_REQ_VALID = 4'b1000;
        acc_ts          = bus.TIMESTAMP;
        exp_q.push_back(3);
        tick();
        bus.S_REQ_VALID = '0;
        check("t6_new_period", longint'(dut.deadline_q[3]), longint'(TW'(acc_ts + 16'd30)));
        service(1, 1'b0);

        // Wrap-around: port 2 holds the grant while ports 0 and 1 arrive across the wrap
        write_period(0, 20);
        write_period(1, 100);
        write_period(2, 64);
        bus.M_READY = 1'b0;
        w = 0;
        while (bus.TIMESTAMP != 16'd65528 && w < 70000) begin
            tick();
            w++;
        end
        check("t4_reach_ts", longint'(bus.TIMESTAMP), 65528);
        bus.S_REQ_VALID = 4'b0100;
        exp_q.push_back(2);
        exp_q.push_back(0);
        exp_q.push_back(1);
        tick();
        bus.S_REQ_VALID = '0;
        tick();
        bus.S_REQ_VALID = 4'b0001;
        tick();
        check("t4_deadline0", longint'(dut.deadline_q[0]), 14);
        bus.S_REQ_VALID = 4'b0010;
        tick();
        check("t4_deadline1", longint'(dut.deadline_q[1]), 95);
        bus.S_REQ_VALID = '0;
        bus.M_READY     = 1'b1;
        service(3, 1'b1);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
